regfile_wb_arbiter: RTL and testbench

//  Shares the single regfile write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg) among
//  NUM_REQ writeback sources (ALU, multdiv, load unit). Round-robin arbitration, valid/ready

---
 rtl/regfile_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared regfile constants used by the writeback arbiter and its round-robin sub-block.
package regfile_pkg;
    localparam int ADDR_W        = 5;
    localparam int DATA_W        = 32;
    localparam int REG_ZERO      = 0;
    localparam int NUM_ARCH_REGS = 32;
    localparam int IDX_W         = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo NUM_REQ.
// It returns a one-hot grant and the encoded winner index.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = regfile_pkg::IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grantIdx,
    output logic               anyGrant
);

    int pos;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        pos      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!anyGrant && req[pos]) begin
                anyGrant   = 1'b1;
                grant[pos] = 1'b1;
                grantIdx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port, followed by one registered writeback stage.
// Optional forwarding ports are added when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_stall,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [IDX_W-1:0]          grant_idx
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         byp_regA,
    input  logic [ADDR_W-1:0]         byp_regB,
    output logic                      byp_hitA,
    output logic                      byp_hitB,
    output logic [DATA_W-1:0]         byp_data
`endif
);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gntIdx;
    logic               anyGnt;
    logic [IDX_W-1:0]   rrPtr;
    logic [IDX_W-1:0]   nextPtr;
    logic               accept;
    logic [ADDR_W-1:0]  selReg;
    logic [DATA_W-1:0]  selData;

    logic               wbVld_p1;
    logic [ADDR_W-1:0]  wbReg_p1;
    logic [DATA_W-1:0]  wbData_p1;
    logic [IDX_W-1:0]   wbIdx_p1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uArb (
        .req      (req_valid),
        .ptr      (rrPtr),
        .grant    (grant),
        .grantIdx (gntIdx),
        .anyGrant (anyGnt)
    );

    // No transfer can complete while reset is held or the writeback register is frozen.
    assign accept    = anyGnt & ~wb_stall & ~ctrl_reset;
    assign req_ready = accept ? grant : '0;
    assign nextPtr   = (int'(gntIdx) == NUM_REQ - 1) ? '0 : gntIdx + IDX_W'(1);

    always_comb begin
        selReg  = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selReg  = req_reg[i*ADDR_W +: ADDR_W];
                selData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p0 -> p1: accepted request enters the writeback register.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wbVld_p1  <= 1'b0;
            wbReg_p1  <= '0;
            wbData_p1 <= '0;
            wbIdx_p1  <= '0;
            rrPtr     <= '0;
        end else if (!wb_stall) begin
            wbVld_p1 <= accept;
            if (accept) begin
                wbReg_p1  <= selReg;
                wbData_p1 <= selData;
                wbIdx_p1  <= gntIdx;
                rrPtr     <= nextPtr;
            end
        end
    end

    // Stage p1 -> regfile: r0 writes complete the handshake but never reach the port.
    assign ctrl_writeEnable = wbVld_p1 & ~wb_stall & (wbReg_p1 != ADDR_W'(REG_ZERO));
    assign ctrl_writeReg    = wbReg_p1;
    assign data_writeReg    = wbData_p1;
    assign grant_idx        = wbIdx_p1;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_hitA = ctrl_writeEnable & (byp_regA == wbReg_p1) & (byp_regA != ADDR_W'(REG_ZERO));
    assign byp_hitB = ctrl_writeEnable & (byp_regB == wbReg_p1) & (byp_regB != ADDR_W'(REG_ZERO));
    assign byp_data = wbData_p1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of arbitration steps plus hand-written corner sequences.
// A scoreboard queue tracks every accepted write until it appears at the regfile port.
module tb_regfile_wb_arbiter;
    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            ctrl_reset;
    logic [NR-1:0]   reqValid;
    logic [NR*AW-1:0] reqReg;
    logic [NR*DW-1:0] reqData;
    logic [NR-1:0]   reqReady;
    logic            wbStall;
    logic            ctrl_writeEnable;
    logic [AW-1:0]   ctrl_writeReg;
    logic [DW-1:0]   data_writeReg;
    logic [2:0]      grantIdx;
`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0]   bypRegA, bypRegB;
    logic            bypHitA, bypHitB;
    logic [DW-1:0]   bypData;
`endif

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .req_valid        (reqValid),
        .req_reg          (reqReg),
        .req_data         (reqData),
        .req_ready        (reqReady),
        .wb_stall         (wbStall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .grant_idx        (grantIdx)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_regA         (bypRegA),
        .byp_regB         (bypRegB),
        .byp_hitA         (bypHitA),
        .byp_hitB         (bypHitB),
        .byp_data         (bypData)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        reqReg[i*AW +: AW]  = r;
        reqData[i*DW +: DW] = d;
    endtask

    // Regfile model fed by the DUT write port.
    logic [DW-1:0] rf [32];
    int r5Writes = 0;
    always @(posedge clock) begin
        if (ctrl_writeEnable) begin
            rf[ctrl_writeReg] <= data_writeReg;
            if (ctrl_writeReg == 5'd5) r5Writes <= r5Writes + 1;
        end
    end

    // Scoreboard: push on handshake, pop when the port writes.
    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        logic [2:0]    idx;
    } wb_t;
    wb_t sbq[$];
    wb_t sbe;

    always @(negedge clock) begin
        if (ctrl_writeEnable) begin
            chk("sb_write_expected", ctrl_writeEnable, (sbq.size() != 0));
            if (sbq.size() != 0) begin
                sbe = sbq.pop_front();
                chk("sb_reg", ctrl_writeReg, sbe.r);
                chk("sb_data", data_writeReg, sbe.d);
                chk("sb_idx", grantIdx, sbe.idx);
            end
        end
        if (ctrl_reset) begin
            sbq.delete();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (reqValid[i] && reqReady[i] && reqReg[i*AW +: AW] != '0) begin
                    sbe.r   = reqReg[i*AW +: AW];
                    sbe.d   = reqData[i*DW +: DW];
                    sbe.idx = 3'(i);
                    sbq.push_back(sbe);
                end
            end
        end
    end

    typedef struct {
        logic [NR-1:0] valid;
        logic          stall;
        logic [NR-1:0] expReady;
        logic          expWe;
    } vec_t;
    vec_t tbl [13];

    int r5Before;

    initial begin
        tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b0};
        tbl[1]  = '{3'b111, 1'b0, 3'b010, 1'b1};
        tbl[2]  = '{3'b111, 1'b0, 3'b100, 1'b1};
        tbl[3]  = '{3'b111, 1'b0, 3'b001, 1'b1};
        tbl[4]  = '{3'b111, 1'b0, 3'b010, 1'b1};
        tbl[5]  = '{3'b111, 1'b0, 3'b100, 1'b1};
        tbl[6]  = '{3'b110, 1'b0, 3'b010, 1'b1};
        tbl[7]  = '{3'b011, 1'b0, 3'b001, 1'b1};
        tbl[8]  = '{3'b000, 1'b0, 3'b000, 1'b1};
        tbl[9]  = '{3'b101, 1'b0, 3'b100, 1'b0};
        tbl[10] = '{3'b111, 1'b1, 3'b000, 1'b0};
        tbl[11] = '{3'b100, 1'b0, 3'b100, 1'b1};
        tbl[12] = '{3'b011, 1'b0, 3'b001, 1'b1};

        for (int i = 0; i < 32; i++) rf[i] = '0;
        ctrl_reset = 1'b1;
        wbStall    = 1'b0;
        reqValid   = 3'b111;
        reqReg     = '0;
        reqData    = '0;
`ifdef REGFILE_WB_BYPASS_EN
        bypRegA = '0;
        bypRegB = '0;
`endif
        for (int i = 0; i < NR; i++) setReq(i, 5'(10 + i), 32'hA000_0000 + 32'(i));

        // Reset held with all requesters pending.
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            chk("reset_we", ctrl_writeEnable, 1'b0);
            chk("reset_ready", reqReady, 3'b000);
            chk("reset_gidx", grantIdx, 3'd0);
            chk("reset_wreg", ctrl_writeReg, 5'd0);
            chk("reset_wdata", data_writeReg, 32'd0);
        end

        // Round-robin and stall table, starting right after reset release.
        for (int i = 0; i < 13; i++) begin
            @(posedge clock);
            #1;
            ctrl_reset = 1'b0;
            reqValid   = tbl[i].valid;
            wbStall    = tbl[i].stall;
            @(negedge clock);
            chk($sformatf("tbl%0d_ready", i), reqReady, tbl[i].expReady);
            chk($sformatf("tbl%0d_we", i), ctrl_writeEnable, tbl[i].expWe);
        end
        @(posedge clock); #1; reqValid = '0; wbStall = 1'b0;
        @(negedge clock);
        chk("drain_we1", ctrl_writeEnable, 1'b1);
        @(posedge clock);
        @(negedge clock);
        chk("drain_we0", ctrl_writeEnable, 1'b0);
        chk("rf_r10", rf[10], 32'hA000_0000);

        // Write to r0: handshake completes, port never enabled.
        @(posedge clock); #1;
        setReq(1, 5'd0, 32'hDEADBEEF);
        reqValid = 3'b010;
        @(negedge clock);
        chk("r0_ready", reqReady, 3'b010);
        @(posedge clock); #1; reqValid = '0;
        @(negedge clock);
        chk("r0_we", ctrl_writeEnable, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk("r0_rf", rf[0], 32'd0);

        // Stall holds an accepted entry; exactly one write after release.
        r5Before = r5Writes;
        @(posedge clock); #1;
        setReq(2, 5'd5, 32'h1234);
        reqValid = 3'b100;
        @(negedge clock);
        chk("stall_grant", reqReady, 3'b100);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            wbStall  = 1'b1;
            reqValid = 3'b111;
            @(negedge clock);
            chk($sformatf("stall%0d_ready", c), reqReady, 3'b000);
            chk($sformatf("stall%0d_we", c), ctrl_writeEnable, 1'b0);
        end
        @(posedge clock); #1;
        wbStall  = 1'b0;
        reqValid = '0;
`ifdef REGFILE_WB_BYPASS_EN
        bypRegA = 5'd5;
        bypRegB = 5'd6;
`endif
        @(negedge clock);
        chk("stall_rel_we", ctrl_writeEnable, 1'b1);
        chk("stall_rel_reg", ctrl_writeReg, 5'd5);
        chk("stall_rel_data", data_writeReg, 32'h1234);
`ifdef REGFILE_WB_BYPASS_EN
        chk("byp_hitA", bypHitA, 1'b1);
        chk("byp_hitB", bypHitB, 1'b0);
        chk("byp_data", bypData, 32'h1234);
        #1 bypRegA = 5'd0;
        #1 chk("byp_hitA_r0", bypHitA, 1'b0);
`endif
        @(posedge clock);
        @(negedge clock);
        chk("stall_after_we", ctrl_writeEnable, 1'b0);
        chk("stall_rf_r5", rf[5], 32'h1234);
        chk("stall_r5_once", 64'(r5Writes - r5Before), 64'd1);

        // Same-target race from rr_ptr=0: later grant wins.
        @(posedge clock); #1; ctrl_reset = 1'b1; reqValid = '0;
        @(posedge clock); #1;
        ctrl_reset = 1'b0;
        setReq(0, 5'd7, 32'd1);
        setReq(1, 5'd7, 32'd2);
        reqValid = 3'b011;
        @(negedge clock);
        chk("race_first", reqReady, 3'b001);
        @(posedge clock); #1; reqValid = 3'b010;
        @(negedge clock);
        chk("race_second", reqReady, 3'b010);
        @(posedge clock); #1; reqValid = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("race_rf_r7", rf[7], 32'd2);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
